// File: rtl/bmem_downsample28.sv
// Crops the centred window of one grayscale frame and writes its block averages to buffer memory.
// Optional macro DS_ROUND_EN selects a rounded, saturated average instead of the truncated one.
module bmem_downsample28 #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CROP_X0  = 96,
  parameter int CROP_Y0  = 16,
  parameter int BLK_LOG2 = 4,
  parameter int OUT_DIM  = 28
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [7:0]  iDATA,
  output logic        oWEN,
  output logic [10:0] oADDR,
  output logic [15:0] oWDATA,
  output logic        oBUSY,
  output logic        oDONE
);

  localparam int CROP_E = OUT_DIM << BLK_LOG2;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H + 1);
  localparam int BXW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int SH     = 2 * BLK_LOG2;

  localparam logic [XW-1:0]  X_LO      = XW'(CROP_X0);
  localparam logic [XW-1:0]  X_SPAN    = XW'(CROP_E);
  localparam logic [XW-1:0]  X_MAX     = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_LO      = YW'(CROP_Y0);
  localparam logic [YW-1:0]  Y_SPAN    = YW'(CROP_E);
  localparam logic [BXW-1:0] BX_LAST   = BXW'(OUT_DIM - 1);
  localparam logic [10:0]    OUT_DIM_A = 11'(OUT_DIM);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

  function automatic logic [7:0] scale_avg(input logic [15:0] s);
`ifdef DS_ROUND_EN
    logic [16:0] r;
    logic [16:0] q;
    r = {1'b0, s} + 17'(1 << (SH - 1));
    q = r >> SH;
    return (q > 17'd255) ? 8'hFF : q[7:0];
`else
    return 8'(s >> SH);
`endif
  endfunction

  state_t          state, state_nxt;
  logic            fval_q;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [15:0]     acc [OUT_DIM];
  logic            wen_p1;
  logic [10:0]     addr_p1;
  logic [15:0]     wdata_p1;
  logic            done;
  logic            busy, done_set, done_clr;

  logic [XW-1:0]   xr;
  logic [YW-1:0]   yr;
  logic [BXW-1:0]  bx, by;
  logic            in_crop, pix, blk_end, last_pix, rise, fall;
  logic [15:0]     sum;
  logic [10:0]     addr_nxt;

  always_comb begin
    xr       = x - X_LO;
    yr       = y - Y_LO;
    in_crop  = (x >= X_LO) && (xr < X_SPAN) && (y >= Y_LO) && (yr < Y_SPAN);
    bx       = xr[BLK_LOG2 +: BXW];
    by       = yr[BLK_LOG2 +: BXW];
    pix      = (state == CAPTURE) && iDVAL;
    blk_end  = in_crop && (&xr[BLK_LOG2-1:0]) && (&yr[BLK_LOG2-1:0]);
    last_pix = pix && blk_end && (bx == BX_LAST) && (by == BX_LAST);
    rise     = iFVAL && !fval_q;
    fall     = !iFVAL && fval_q;
    sum      = acc[bx] + {8'h00, iDATA};
    addr_nxt = 11'(by) * OUT_DIM_A + 11'(bx);
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (iSTART) state_nxt = WAIT_SOF;
      WAIT_SOF: if (rise) state_nxt = CAPTURE;
      CAPTURE: begin
        if (last_pix)  state_nxt = DONE;
        else if (fall) state_nxt = WAIT_SOF;
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == WAIT_SOF) || (state == CAPTURE);
    done_set = (state == DONE);
    done_clr = (state == IDLE) && iSTART;
  end

  // p0 -> p1: pixel accumulate, block completion registered onto the write port
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      fval_q   <= 1'b0;
      x        <= '0;
      y        <= '0;
      wen_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      done     <= 1'b0;
      for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
    end else begin
      fval_q <= iFVAL;
      wen_p1 <= pix && blk_end;
      if (done_clr)      done <= 1'b0;
      else if (done_set) done <= 1'b1;

      if (pix && blk_end) begin
        addr_p1  <= addr_nxt;
        wdata_p1 <= {8'h00, scale_avg(sum)};
      end

      if (state == WAIT_SOF) begin
        x <= '0;
        y <= '0;
      end else if (pix) begin
        if (x == X_MAX) begin
          x <= '0;
          y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end

      // A short frame leaves partial sums behind; drop them so the retry starts clean.
      if ((state == CAPTURE) && fall && !last_pix) begin
        for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
        x <= '0;
        y <= '0;
      end else if (pix && in_crop) begin
        acc[bx] <= blk_end ? 16'h0000 : sum;
      end
    end
  end

  assign oWEN   = wen_p1;
  assign oADDR  = addr_p1;
  assign oWDATA = wdata_p1;
  assign oBUSY  = busy;
  assign oDONE  = done;

endmodule
